// File: rtl/r_ctrl_fsm.sv
// r_ctrl_fsm: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control unit for the
// R-type MIPS core. It fetches from a combinational ROM addressed by pc,
// latches the word into ir, decodes the funct field into an ALU code, and
// strobes the register-file write during WRITEBACK.
module r_ctrl_fsm #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          RET_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       state,
  output logic             illegal,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t     st;
  logic [3:0] dec;

  // Returns {legal, alu_code}; anything outside the supported R-type set,
  // including non-zero opcodes, shifts and the unsigned add/sub forms, is illegal.
  function automatic logic [3:0] decode_r(input logic [5:0] opcode,
                                          input logic [5:0] funct);
    logic [3:0] r;
    r = 4'b0000;
    if (opcode == 6'd0) begin
      case (funct)
        6'h24:   r = 4'b1_000;  // AND
        6'h25:   r = 4'b1_001;  // OR
        6'h20:   r = 4'b1_010;  // ADD
        6'h26:   r = 4'b1_011;  // XOR
        6'h27:   r = 4'b1_100;  // NOR
        6'h22:   r = 4'b1_110;  // SUB
        6'h2A:   r = 4'b1_111;  // SLT
        default: r = 4'b0_000;
      endcase
    end
    return r;
  endfunction

  assign dec   = decode_r(ir[31:26], ir[5:0]);
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign state = st;

  // Write strobe is combinational so that a stall or reset in WRITEBACK
  // suppresses it in the same cycle; writes to $0 are never issued.
  assign reg_we = (st == WRITEBACK) && EN && (rd != 5'd0);

  // Main sequencer: every register advances only on enabled edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st      <= FETCH;
      pc      <= PC_RESET;
      ir      <= '0;
      alu_op  <= 3'b000;
      illegal <= 1'b0;
      retired <= '0;
    end else if (EN) begin
      case (st)
        FETCH: begin
          ir      <= inst;
          pc      <= pc + 32'd4;
          illegal <= 1'b0;
          st      <= DECODE;
        end
        DECODE: begin
          if (dec[3]) begin
            alu_op <= dec[2:0];
            st     <= EXECUTE;
          end else begin
            // alu_op deliberately keeps the last legal code
            illegal <= 1'b1;
            st      <= FETCH;
          end
        end
        EXECUTE: begin
          st <= WRITEBACK;
        end
        WRITEBACK: begin
          retired <= retired + RET_W'(1);
          st      <= FETCH;
        end
        default: begin
          st <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_ctrl_fsm.sv
// Testbench for r_ctrl_fsm: reset values, directed multi-cycle sequences,
// a table of decode vectors, pc/counter wrap via a second instance, and a
// randomized run against an instruction-level reference model.
module tb_r_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [31:0] inst, inst2;
  logic [31:0] pc, ir, pc2, ir2;
  logic [4:0]  rs, rt, rd, rs2, rt2, rd2;
  logic [2:0]  alu_op, alu_op2;
  logic        reg_we, reg_we2, illegal, illegal2;
  logic [1:0]  state, state2;
  logic [15:0] retired;
  logic [1:0]  retired2;

  logic [31:0] rom [16];

  int n_cmp = 0;
  int n_err = 0;

  assign inst  = rom[pc[5:2]];
  assign inst2 = rom[pc2[5:2]];

  always #5 CLK = ~CLK;

  r_ctrl_fsm #(.PC_RESET(32'h0000_0000), .RET_W(16)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .inst(inst),
    .pc(pc), .ir(ir), .rs(rs), .rt(rt), .rd(rd),
    .alu_op(alu_op), .reg_we(reg_we), .state(state),
    .illegal(illegal), .retired(retired)
  );

  // Second instance starts at the top of the address space with a 2-bit
  // retired counter so both wrap-arounds are reachable quickly.
  r_ctrl_fsm #(.PC_RESET(32'hFFFF_FFFC), .RET_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .inst(inst2),
    .pc(pc2), .ir(ir2), .rs(rs2), .rt(rt2), .rd(rd2),
    .alu_op(alu_op2), .reg_we(reg_we2), .state(state2),
    .illegal(illegal2), .retired(retired2)
  );

  localparam logic [31:0] W_ADD  = 32'h0022_1820;
  localparam logic [31:0] W_SUB  = 32'h0062_2022;
  localparam logic [31:0] W_SLT  = 32'h0022_282A;
  localparam logic [31:0] W_LW   = 32'h8C01_0000;
  localparam logic [31:0] W_ADD0 = 32'h0022_0020;

  typedef struct {
    logic [31:0] w;
    logic        legal;
    logic [2:0]  alu;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [2:0]  alu;
    logic [1:0]  st;
    logic        ill;
    logic [15:0] ret;
  } snap_t;

  snap_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN  = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic rom_fill(input logic [31:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  // Spec-level decode table: returns legality and ALU code for a word.
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [5:0] f;
    f = w[5:0];
    if (w[31:26] != 6'd0) return 4'b0000;
    if (f == 6'h24) return 4'b1000;
    if (f == 6'h25) return 4'b1001;
    if (f == 6'h20) return 4'b1010;
    if (f == 6'h26) return 4'b1011;
    if (f == 6'h27) return 4'b1100;
    if (f == 6'h22) return 4'b1110;
    if (f == 6'h2A) return 4'b1111;
    return 4'b0000;
  endfunction

  // Instruction-level model: walks the program from reset and appends the
  // architectural snapshot expected after each enabled edge.
  task automatic build_expected(input int n_edges);
    logic [31:0] mpc, w;
    logic [2:0]  malu;
    logic [15:0] mret;
    logic [3:0]  d;
    snap_t       s;
    q.delete();
    mpc = 32'h0; malu = 3'b000; mret = 16'h0;
    s = '{pc: 32'h0, ir: 32'h0, alu: 3'b000, st: 2'd0, ill: 1'b0, ret: 16'h0};
    q.push_back(s);
    while (q.size() <= n_edges) begin
      w   = rom[(mpc >> 2) % 16];
      mpc = mpc + 32'd4;
      d   = ref_decode(w);
      q.push_back('{pc: mpc, ir: w, alu: malu, st: 2'd1, ill: 1'b0, ret: mret});
      if (d[3]) begin
        malu = d[2:0];
        q.push_back('{pc: mpc, ir: w, alu: malu, st: 2'd2, ill: 1'b0, ret: mret});
        q.push_back('{pc: mpc, ir: w, alu: malu, st: 2'd3, ill: 1'b0, ret: mret});
        mret = mret + 16'd1;
        q.push_back('{pc: mpc, ir: w, alu: malu, st: 2'd0, ill: 1'b0, ret: mret});
      end else begin
        q.push_back('{pc: mpc, ir: w, alu: malu, st: 2'd0, ill: 1'b1, ret: mret});
      end
    end
  endtask

  task automatic random_program();
    logic [5:0] legal_f [7];
    logic [31:0] w;
    legal_f = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h22, 6'h2A};
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0, 1: begin w[31:26] = 6'd0; w[5:0] = legal_f[$urandom_range(0, 6)]; end
        2:    begin w[31:26] = 6'd0; end
        default: ;
      endcase
      rom[i] = w;
    end
  endtask

  task automatic random_run(input int n_cycles);
    int    idx;
    snap_t c;
    build_expected(n_cycles + 4);
    do_reset();
    idx = 0;
    for (int k = 0; k < n_cycles; k++) begin
      EN = ($urandom_range(0, 3) != 0);
      c  = q[idx];
      #1;
      chk("rnd_reg_we", reg_we, EN && (c.st == 2'd3) && (c.ir[15:11] != 5'd0));
      tick();
      if (EN) idx++;
      c = q[idx];
      chk("rnd_pc", pc, c.pc);
      chk("rnd_ir", ir, c.ir);
      chk("rnd_state", state, c.st);
      chk("rnd_alu_op", alu_op, c.alu);
      chk("rnd_illegal", illegal, c.ill);
      chk("rnd_retired", retired, c.ret);
      chk("rnd_rd", rd, c.ir[15:11]);
    end
    EN = 1'b1;
  endtask

  initial begin
    vec_t vt [10];
    vt[0] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h24}, legal: 1'b1, alu: 3'b000};
    vt[1] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, legal: 1'b1, alu: 3'b001};
    vt[2] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 6'h20}, legal: 1'b1, alu: 3'b010};
    vt[3] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h26}, legal: 1'b1, alu: 3'b011};
    vt[4] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h27}, legal: 1'b1, alu: 3'b100};
    vt[5] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, legal: 1'b1, alu: 3'b110};
    vt[6] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, legal: 1'b1, alu: 3'b111};
    vt[7] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, legal: 1'b0, alu: 3'b000};
    vt[8] = '{w: {6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h00}, legal: 1'b0, alu: 3'b000};
    vt[9] = '{w: {6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, legal: 1'b0, alu: 3'b000};

    RST = 1'b0;
    EN  = 1'b1;
    rom_fill(32'h0);

    // Reset values, then ADD $3,$1,$2 through all four phases.
    rom[0] = W_ADD;
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", state, 2'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_alu_op", alu_op, 3'b000);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_illegal", illegal, 1'b0);
    tick();
    chk("add_ir", ir, W_ADD);
    chk("add_pc", pc, 32'd4);
    chk("add_we_dec", reg_we, 1'b0);
    tick();
    chk("add_alu_op", alu_op, 3'b010);
    chk("add_rs", rs, 5'd1);
    chk("add_rt", rt, 5'd2);
    chk("add_rd", rd, 5'd3);
    chk("add_we_ex", reg_we, 1'b0);
    tick();
    chk("add_state_wb", state, 2'd3);
    chk("add_we_wb", reg_we, 1'b1);
    tick();
    chk("add_state_end", state, 2'd0);
    chk("add_retired", retired, 16'd1);
    chk("add_we_end", reg_we, 1'b0);

    // SUB then SLT.
    rom_fill(32'h0);
    rom[0] = W_SUB;
    rom[1] = W_SLT;
    do_reset();
    ticks(2);
    chk("sub_alu_op", alu_op, 3'b110);
    ticks(4);
    chk("slt_alu_op", alu_op, 3'b111);
    ticks(2);
    chk("subslt_retired", retired, 16'd2);
    chk("subslt_pc", pc, 32'd8);

    // Illegal word after a legal SUB: alu_op keeps 110, two-cycle turnaround.
    rom_fill(32'h0);
    rom[0] = W_SUB;
    rom[1] = W_LW;
    rom[2] = W_ADD;
    do_reset();
    ticks(4);
    chk("ill_pre_retired", retired, 16'd1);
    tick();
    chk("ill_we_dec", reg_we, 1'b0);
    tick();
    chk("ill_flag", illegal, 1'b1);
    chk("ill_state", state, 2'd0);
    chk("ill_alu_held", alu_op, 3'b110);
    chk("ill_we_fetch", reg_we, 1'b0);
    tick();
    chk("ill_flag_clr", illegal, 1'b0);
    chk("ill_pc_next", pc, 32'd12);
    chk("ill_ir_next", ir, W_ADD);
    chk("ill_retired", retired, 16'd1);

    // rd = 0 with a 3-cycle stall in WRITEBACK: no strobe at all.
    rom_fill(32'h0);
    rom[0] = W_ADD0;
    do_reset();
    ticks(3);
    chk("rd0_state_wb", state, 2'd3);
    chk("rd0_we_wb", reg_we, 1'b0);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd0_we_stall", reg_we, 1'b0);
      tick();
      chk("rd0_state_frozen", state, 2'd3);
      chk("rd0_ret_frozen", retired, 16'd0);
    end
    EN = 1'b1;
    #1;
    chk("rd0_we_release", reg_we, 1'b0);
    tick();
    chk("rd0_retired", retired, 16'd1);
    chk("rd0_state_end", state, 2'd0);

    // rd != 0 stalled in WRITEBACK: strobe only once EN returns.
    rom_fill(32'h0);
    rom[0] = W_ADD;
    do_reset();
    ticks(3);
    EN = 1'b0;
    #1;
    chk("stall_we_low", reg_we, 1'b0);
    tick();
    chk("stall_state", state, 2'd3);
    chk("stall_ret", retired, 16'd0);
    EN = 1'b1;
    #1;
    chk("stall_we_back", reg_we, 1'b1);
    tick();
    chk("stall_retired", retired, 16'd1);

    // Reset asserted mid-EXECUTE of the second instruction.
    rom_fill(32'h0);
    rom[0] = W_ADD;
    rom[1] = W_SUB;
    do_reset();
    ticks(6);
    chk("rmid_pre_state", state, 2'd2);
    chk("rmid_pre_ret", retired, 16'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("rmid_state", state, 2'd0);
    chk("rmid_pc", pc, 32'd0);
    chk("rmid_retired", retired, 16'd0);
    chk("rmid_ir", ir, 32'd0);
    chk("rmid_alu", alu_op, 3'b000);
    chk("rmid_we", reg_we, 1'b0);
    tick();
    RST = 1'b0;
    chk("rmid_hold_pc", pc, 32'd0);
    tick();
    chk("rmid_refetch_ir", ir, W_ADD);
    chk("rmid_refetch_pc", pc, 32'd4);

    // Table of decode vectors.
    for (int i = 0; i < 10; i++) begin
      rom_fill(W_ADD);
      rom[0] = vt[i].w;
      do_reset();
      ticks(2);
      chk($sformatf("tbl%0d_state", i), state, vt[i].legal ? 2'd2 : 2'd0);
      chk($sformatf("tbl%0d_illegal", i), illegal, !vt[i].legal);
      chk($sformatf("tbl%0d_alu", i), alu_op, vt[i].alu);
    end

    // pc wrap and retired-counter wrap on the second instance.
    rom_fill(W_ADD);
    do_reset();
    chk("wrap_pc_rst", pc2, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_ir", ir2, W_ADD);
    ticks(11);
    chk("wrap_ret3", retired2, 2'd3);
    ticks(4);
    chk("wrap_ret0", retired2, 2'd0);
    chk("wrap_ret_wide", retired, 16'd4);

    // Randomized programs and enables against the instruction-level model.
    for (int r = 0; r < 4; r++) begin
      random_program();
      random_run(400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
